// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1-style UART transmitter.
// Latency: a write into an empty FIFO with the transmitter idle starts the
// start bit on the following edge. Frames are sent back-to-back while data
// is queued.
// Backpressure: writes while full are dropped, and the sticky overflow flag
// records the loss.
// Ports:
//   clk, reset       - sole clock (rising edge) and synchronous active-high reset
//   wr_en, wr_data   - write strobe and payload to queue
//   full, empty      - FIFO status
//   level            - number of stored entries
//   overflow         - sticky flag: a write was dropped
//   txd              - registered serial line, idle high
//   busy             - transmitter not idle
//   frame_done       - one-cycle pulse on the edge that ends the last stop bit
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int GAP_BITS     = 0,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          txd,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP  = 4'(STOP_BITS - 1);
    localparam logic [3:0]    LAST_GAP   = 4'(GAP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic                 r_overflow;

    // Transmitter state
    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_txd;
    logic                 r_frame_done;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_stop_end;
    logic                 w_frame_end;
    logic [DATA_BITS-1:0] w_head;

    assign w_full    = (r_level == LW'(FIFO_DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_push    = wr_en && !w_full;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_bit_end = (r_cnt == '0);

    // Last stop bit ends the frame proper; the frame is only finished for
    // the line once any trailing gap bits have also elapsed.
    assign w_stop_end  = (r_state == S_STOP) && w_bit_end && (r_idx == LAST_STOP);
    assign w_frame_end = (w_stop_end && (GAP_BITS == 0)) ||
                         ((r_state == S_GAP) && w_bit_end && (r_idx == LAST_GAP));

    // A new frame starts either from idle or straight off the end of the
    // previous frame, so no idle cycle appears between queued bytes.
    assign w_pop = !w_empty && ((r_state == S_IDLE) || w_frame_end);

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_txd        <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_stop_end;
            if (w_pop) begin
                // Parity is computed once from the whole byte at load time.
                r_shift <= w_head;
                r_par   <= (^w_head) ^ (PARITY == 1);
                r_txd   <= 1'b0;
                r_state <= S_START;
                r_cnt   <= CNT_RELOAD;
                r_idx   <= '0;
            end else if (r_state == S_IDLE) begin
                r_txd <= 1'b1;
            end else if (!w_bit_end) begin
                r_cnt <= r_cnt - CW'(1);
            end else begin
                r_cnt <= CNT_RELOAD;
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_txd   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_idx   <= '0;
                    end
                    S_DATA: begin
                        if (r_idx == LAST_DATA) begin
                            r_idx <= '0;
                            if (PARITY != 0) begin
                                r_state <= S_PARITY;
                                r_txd   <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_txd   <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_idx   <= r_idx + 4'd1;
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
                        r_idx   <= '0;
                    end
                    S_STOP: begin
                        r_txd <= 1'b1;
                        if (r_idx == LAST_STOP) begin
                            r_idx   <= '0;
                            r_state <= (GAP_BITS != 0) ? S_GAP : S_IDLE;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                    S_GAP: begin
                        r_txd <= 1'b1;
                        if (r_idx == LAST_GAP) begin
                            r_idx   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_txd   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign full       = w_full;
    assign empty      = w_empty;
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign txd        = r_txd;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, clocks per serial bit (>=2).
REQ-002 SHALL have parameter DATA_BITS, default 8, payload bits per frame (5..9).
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-005 SHALL have parameter GAP_BITS, default 0, idle bit-times forced after each frame (0..15).
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, entries, power of two, >=2.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous reset, active-high.
REQ-009 SHALL have port wr_en, input, 1, write strobe.
REQ-010 SHALL have port wr_data, input, DATA_BITS, byte to queue.
REQ-011 SHALL have port full, output, 1, FIFO full.
REQ-012 SHALL have port empty, output, 1, FIFO empty.
REQ-013 SHALL have port level, output, $clog2(FIFO_DEPTH)+1, stored entry count.
REQ-014 SHALL have port overflow, output, 1, sticky: a write was dropped.
REQ-015 SHALL have port txd, output, 1, serial line, registered, idle high.
REQ-016 SHALL have port busy, output, 1, high whenever state != IDLE.
REQ-017 SHALL have port frame_done, output, 1, one-cycle pulse per completed frame.

Function
REQ-018 SHALL accept a write iff wr_en=1 and full=0 on that edge; full is judged on the pre-edge state, so a same-cycle pop does not make room.
REQ-019 SHALL set overflow when wr_en=1 and full=1; overflow clears only on reset.
REQ-020 SHALL keep level = writes accepted - pops; full = (level==FIFO_DEPTH), empty = (level==0); pointers wrap modulo FIFO_DEPTH.
REQ-021 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, GAP.
REQ-022 IDLE: when empty=0, SHALL pop the head entry into a shift register, drive txd=0 and enter START on the same edge.
REQ-023 A write accepted at edge E into an empty FIFO with FSM in IDLE SHALL produce txd=0 from edge E+1.
REQ-024 Every bit (start, data, parity, stop, gap) SHALL last exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at each bit boundary.
REQ-025 DATA SHALL send DATA_BITS bits LSB first; PARITY state SHALL be skipped when PARITY=0.
REQ-026 Parity bit SHALL be XOR of data bits (even) or its inverse (odd).
REQ-027 STOP SHALL drive txd=1 for STOP_BITS bit-times; GAP SHALL drive txd=1 for GAP_BITS bit-times and SHALL be skipped when GAP_BITS=0.
REQ-028 frame_done SHALL pulse on the edge ending the last stop bit.
REQ-029 At the end of the last stop/gap bit, if empty=0, SHALL pop and enter START directly (no extra idle cycle); otherwise SHALL enter IDLE.
REQ-030 Frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS+GAP_BITS)*CLKS_PER_BIT cycles.
REQ-031 Writes during transmission SHALL not disturb the frame in flight.

Reset
REQ-032 While reset=1 at an edge: txd=1, busy=0, empty=1, full=0, level=0, overflow=0, frame_done=0, state=IDLE, counters and pointers zero.
REQ-033 Reset mid-frame SHALL abort the frame and discard FIFO contents; wr_en during reset SHALL be ignored.

Verification
REQ-034 Defaults, write 0x36 -> txd low 217 cycles from next edge, then 0,1,1,0,1,1,0,0 at 217 cycles each, stop high; frame_done at cycle 2170; busy falls same edge.
REQ-035 PARITY=2, write 0x2A -> parity bit 1; PARITY=1 same byte -> parity bit 0; frame 2387 cycles.
REQ-036 Writes 0x39,0x39,0x2F,0x33 on consecutive cycles -> four frames back-to-back, no idle gap, four frame_done pulses 2170 cycles apart, empty=1 at end.
REQ-037 FIFO_DEPTH=4, six consecutive writes A..F -> A popped immediately, B..E stored (full=1), F dropped, overflow=1; line carries A,B,C,D,E only.
REQ-038 Reset pulse of one cycle during DATA bit 3 with 2 bytes queued -> after that edge txd=1, busy=0, level=0, no further frames.
REQ-039 STOP_BITS=2, GAP_BITS=1, two queued bytes -> second start bit begins exactly 12*217=2604 cycles after first.
